// File: rtl/log_reservation_station.sv
// Reservation station for the logical execution unit: holds dispatched ops until
// both operands are known, snoops the CDB, issues in lowest-index order.
package log_rs_pkg;
    typedef struct packed {
        logic [2:0] operation;
        logic       alter_cr0;
    } log_decode_t;
endpackage

module log_reservation_station
    import log_rs_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_ID_BASE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic                   disp_op1_valid,
    input  logic                   disp_op2_valid,
    input  logic [31:0]            disp_op1,
    input  logic [31:0]            disp_op2,
    input  logic [RS_ID_WIDTH-1:0] disp_op1_tag,
    input  logic [RS_ID_WIDTH-1:0] disp_op2_tag,
    input  logic                   disp_so,
    input  log_decode_t            disp_control,
    input  logic [4:0]             disp_result_reg_addr,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [4:0]             issue_result_reg_addr,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output logic                   issue_so,
    output log_decode_t            issue_control
);

    typedef enum logic [1:0] {ST_FREE, ST_WAITING, ST_READY, ST_ISSUED} entry_state_t;

    entry_state_t           state_reg     [DEPTH];
    logic                   op1_valid_reg [DEPTH];
    logic                   op2_valid_reg [DEPTH];
    logic [31:0]            op1_reg       [DEPTH];
    logic [31:0]            op2_reg       [DEPTH];
    logic [RS_ID_WIDTH-1:0] op1_tag_reg   [DEPTH];
    logic [RS_ID_WIDTH-1:0] op2_tag_reg   [DEPTH];
    logic                   so_reg        [DEPTH];
    log_decode_t            control_reg   [DEPTH];
    logic [4:0]             rd_reg        [DEPTH];

    logic [DEPTH-1:0] free_vec, ready_vec, alloc_oh, issue_oh;
    logic [DEPTH-1:0] hit1_vec, hit2_vec, done_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
            localparam logic [RS_ID_WIDTH-1:0] ENTRY_ID = RS_ID_WIDTH'(RS_ID_BASE + gi);
            assign free_vec[gi]  = (state_reg[gi] == ST_FREE);
            assign ready_vec[gi] = (state_reg[gi] == ST_READY);
            assign hit1_vec[gi]  = cdb_valid && !op1_valid_reg[gi] && (op1_tag_reg[gi] == cdb_rs_id);
            assign hit2_vec[gi]  = cdb_valid && !op2_valid_reg[gi] && (op2_tag_reg[gi] == cdb_rs_id);
            assign done_vec[gi]  = cdb_valid && (state_reg[gi] == ST_ISSUED) && (cdb_rs_id == ENTRY_ID);
        end
    endgenerate

    always_comb begin
        logic free_seen;
        logic ready_seen;
        free_seen  = 1'b0;
        ready_seen = 1'b0;
        alloc_oh   = '0;
        issue_oh   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_oh[i] = free_vec[i] && !free_seen;
            issue_oh[i] = ready_vec[i] && !ready_seen;
            free_seen   = free_seen | free_vec[i];
            ready_seen  = ready_seen | ready_vec[i];
        end
    end

    // disp_ready looks only at registered state, so a same-cycle completion cannot be reused yet
    assign disp_ready  = |free_vec;
    assign issue_valid = |ready_vec;

    logic        disp_fire, issue_fire;
    logic        disp_hit1, disp_hit2, disp_ok1, disp_ok2;
    logic [31:0] disp_val1, disp_val2;

    assign disp_fire  = disp_valid && disp_ready;
    assign issue_fire = issue_valid && issue_ready;
    assign disp_hit1  = cdb_valid && !disp_op1_valid && (disp_op1_tag == cdb_rs_id);
    assign disp_hit2  = cdb_valid && !disp_op2_valid && (disp_op2_tag == cdb_rs_id);
    assign disp_ok1   = disp_op1_valid || disp_hit1;
    assign disp_ok2   = disp_op2_valid || disp_hit2;
    assign disp_val1  = disp_op1_valid ? disp_op1 : (disp_hit1 ? cdb_result : 32'd0);
    assign disp_val2  = disp_op2_valid ? disp_op2 : (disp_hit2 ? cdb_result : 32'd0);

    always_comb begin
        issue_rs_id           = '0;
        issue_result_reg_addr = '0;
        issue_op1             = '0;
        issue_op2             = '0;
        issue_so              = 1'b0;
        issue_control         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_oh[i]) begin
                issue_rs_id           = RS_ID_WIDTH'(RS_ID_BASE + i);
                issue_result_reg_addr = rd_reg[i];
                issue_op1             = op1_reg[i];
                issue_op2             = op2_reg[i];
                issue_so              = so_reg[i];
                issue_control         = control_reg[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_reg[i]     <= ST_FREE;
                op1_valid_reg[i] <= 1'b0;
                op2_valid_reg[i] <= 1'b0;
                op1_reg[i]       <= '0;
                op2_reg[i]       <= '0;
                op1_tag_reg[i]   <= '0;
                op2_tag_reg[i]   <= '0;
                so_reg[i]        <= 1'b0;
                control_reg[i]   <= '0;
                rd_reg[i]        <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                case (state_reg[i])
                    ST_FREE: begin
                        if (disp_fire && alloc_oh[i]) begin
                            op1_valid_reg[i] <= disp_ok1;
                            op2_valid_reg[i] <= disp_ok2;
                            op1_reg[i]       <= disp_val1;
                            op2_reg[i]       <= disp_val2;
                            op1_tag_reg[i]   <= disp_op1_tag;
                            op2_tag_reg[i]   <= disp_op2_tag;
                            so_reg[i]        <= disp_so;
                            control_reg[i]   <= disp_control;
                            rd_reg[i]        <= disp_result_reg_addr;
                            state_reg[i]     <= (disp_ok1 && disp_ok2) ? ST_READY : ST_WAITING;
                        end
                    end
                    ST_WAITING: begin
                        if (hit1_vec[i]) begin
                            op1_valid_reg[i] <= 1'b1;
                            op1_reg[i]       <= cdb_result;
                        end
                        if (hit2_vec[i]) begin
                            op2_valid_reg[i] <= 1'b1;
                            op2_reg[i]       <= cdb_result;
                        end
                        if ((op1_valid_reg[i] || hit1_vec[i]) && (op2_valid_reg[i] || hit2_vec[i]))
                            state_reg[i] <= ST_READY;
                    end
                    ST_READY: begin
                        if (issue_fire && issue_oh[i])
                            state_reg[i] <= ST_ISSUED;
                    end
                    ST_ISSUED: begin
                        if (done_vec[i])
                            state_reg[i] <= ST_FREE;
                    end
                    default: state_reg[i] <= ST_FREE;
                endcase
            end
        end
    end

endmodule
